// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer/counter on the CPU data bus.
// Register window (16 bytes at BASE_ADDR): 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS.
// Read data is combinational so single-cycle loads complete in the same cycle.
// Optional feature macro: TIMER_IRQ_EN adds CTRL.IRQEN and the registered o_Irq output.
module mmio_timer #(
   parameter int ADDR_DBUS_WIDTH = 32,
   parameter int DATA_DBUS_WIDTH = 32,
   parameter logic [ADDR_DBUS_WIDTH-1:0] BASE_ADDR = 32'h0001_0000
) (
   input  logic                       i_Clock,
   input  logic                       i_Reset,
   input  logic [ADDR_DBUS_WIDTH-1:0] i_MemAddr,
   input  logic                       i_MemWrEnable,
   input  logic [DATA_DBUS_WIDTH-1:0] i_MemWrData,
   output logic [DATA_DBUS_WIDTH-1:0] o_MemRdData,
   output logic                       o_Sel
`ifdef TIMER_IRQ_EN
   ,
   output logic                       o_Irq
`endif
);

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_COUNT   = 2'd1;
   localparam logic [1:0] REG_COMPARE = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   // Architectural state
   logic                       r_en;
   logic                       r_autoreload;
   logic [15:0]                r_prescale;
   logic [15:0]                r_pcnt;
   logic [DATA_DBUS_WIDTH-1:0] r_count;
   logic [DATA_DBUS_WIDTH-1:0] r_compare;
   logic                       r_match;
   logic                       r_ovf;

   // Decode and event wires
   logic                       w_hit;
   logic [1:0]                 w_reg_sel;
   logic                       w_wr;
   logic                       w_wr_ctrl;
   logic                       w_wr_count;
   logic                       w_wr_compare;
   logic                       w_wr_status;
   logic                       w_tick;
   logic [DATA_DBUS_WIDTH-1:0] w_count_inc;
   logic                       w_set_match;
   logic                       w_set_ovf;
   logic                       w_irqen_rd;
   logic [DATA_DBUS_WIDTH-1:0] w_rd_data;
   logic [1:0]                 w_unused_addr_lsb;

   // Byte offset within a word has no meaning for this word-only register file.
   assign w_unused_addr_lsb = i_MemAddr[1:0];

   assign w_hit        = (i_MemAddr[ADDR_DBUS_WIDTH-1:4] == BASE_ADDR[ADDR_DBUS_WIDTH-1:4]);
   assign w_reg_sel    = i_MemAddr[3:2];
   assign w_wr         = i_MemWrEnable & w_hit;
   assign w_wr_ctrl    = w_wr & (w_reg_sel == REG_CTRL);
   assign w_wr_count   = w_wr & (w_reg_sel == REG_COUNT);
   assign w_wr_compare = w_wr & (w_reg_sel == REG_COMPARE);
   assign w_wr_status  = w_wr & (w_reg_sel == REG_STATUS);

   // A tick fires in the cycle the prescale counter reaches PRESCALE.
   assign w_tick      = r_en & (r_pcnt == r_prescale);
   assign w_count_inc = r_count + 32'd1;
   assign w_set_ovf   = w_tick & (r_count == {DATA_DBUS_WIDTH{1'b1}});
   assign w_set_match = w_tick & (w_count_inc == r_compare);

   // Prescale counter: restarts on a CTRL write, on every tick, and is parked at 0 while disabled.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_pcnt <= 16'd0;
      end else if (w_wr_ctrl || !r_en || w_tick) begin
         r_pcnt <= 16'd0;
      end else begin
         r_pcnt <= r_pcnt + 16'd1;
      end
   end

   // CTRL register fields.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_en         <= 1'b0;
         r_autoreload <= 1'b0;
         r_prescale   <= 16'd0;
      end else if (w_wr_ctrl) begin
         r_en         <= i_MemWrData[0];
         r_autoreload <= i_MemWrData[1];
         r_prescale   <= i_MemWrData[31:16];
      end
   end

   // COUNT: a CPU store overrides the tick increment issued in the same cycle.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_count <= {DATA_DBUS_WIDTH{1'b0}};
      end else if (w_wr_count) begin
         r_count <= i_MemWrData;
      end else if (w_tick) begin
         r_count <= (w_set_match && r_autoreload) ? {DATA_DBUS_WIDTH{1'b0}} : w_count_inc;
      end
   end

   // COMPARE register; a new value is seen by the match logic from the following cycle.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_compare <= {DATA_DBUS_WIDTH{1'b1}};
      end else if (w_wr_compare) begin
         r_compare <= i_MemWrData;
      end
   end

   // Sticky status flags: hardware set takes priority over a same-cycle write-1-to-clear.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_match <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_match <= w_set_match | (r_match & ~(w_wr_status & i_MemWrData[0]));
         r_ovf   <= w_set_ovf   | (r_ovf   & ~(w_wr_status & i_MemWrData[1]));
      end
   end

`ifdef TIMER_IRQ_EN
   logic r_irqen;
   logic r_irq;

   // IRQEN bit of CTRL.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_irqen <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_irqen <= i_MemWrData[2];
      end
   end

   // Level interrupt, registered from the visible flag state.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_irqen & (r_match | r_ovf);
      end
   end

   assign w_irqen_rd = r_irqen;
   assign o_Irq      = r_irq;
`else
   assign w_irqen_rd = 1'b0;
`endif

   // Combinational read mux; a miss returns zero so the top level can OR/mux freely.
   always_comb begin
      w_rd_data = {DATA_DBUS_WIDTH{1'b0}};
      if (w_hit) begin
         case (w_reg_sel)
            REG_CTRL:    w_rd_data = {r_prescale, 13'd0, w_irqen_rd, r_autoreload, r_en};
            REG_COUNT:   w_rd_data = r_count;
            REG_COMPARE: w_rd_data = r_compare;
            REG_STATUS:  w_rd_data = {30'd0, r_ovf, r_match};
            default:     w_rd_data = {DATA_DBUS_WIDTH{1'b0}};
         endcase
      end else begin
         w_rd_data = {DATA_DBUS_WIDTH{1'b0}};
      end
   end

   assign o_MemRdData = w_rd_data;
   assign o_Sel       = w_hit;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer. All bus activity is launched on the
// falling clock edge; each bus_write/bus_read call occupies exactly one clock cycle,
// so the store edge is the rising edge inside that cycle and reads sample 1ns after
// the falling edge.
module tb_mmio_timer;

   localparam logic [31:0] BASE    = 32'h0001_0000;
   localparam logic [31:0] A_CTRL  = 32'h0001_0000;
   localparam logic [31:0] A_COUNT = 32'h0001_0004;
   localparam logic [31:0] A_CMP   = 32'h0001_0008;
   localparam logic [31:0] A_STAT  = 32'h0001_000C;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        sel;
   wire         irq;

   logic [31:0] rd_v;
   logic        sel_v;
   logic        irq_v;
   int          checks;
   int          errors;

   mmio_timer #(
      .ADDR_DBUS_WIDTH(32),
      .DATA_DBUS_WIDTH(32),
      .BASE_ADDR(BASE)
   ) dut (
      .i_Clock       (clk),
      .i_Reset       (rst_n),
      .i_MemAddr     (addr),
      .i_MemWrEnable (we),
      .i_MemWrData   (wdata),
      .o_MemRdData   (rdata),
      .o_Sel         (sel)
`ifdef TIMER_IRQ_EN
      ,
      .o_Irq         (irq)
`endif
   );

`ifndef TIMER_IRQ_EN
   assign irq = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      addr = a;
      we   = 1'b0;
      #1;
      rd_v  = rdata;
      sel_v = sel;
      irq_v = irq;
      @(negedge clk);
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus_read(a);
      check_eq(tag, rd_v, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      addr   = 32'd0;
      we     = 1'b0;
      wdata  = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset while counting
      bus_write(A_CTRL, 32'h0002_0001);
      bus_write(A_CMP, 32'h0000_0010);
      idle(7);
      #2;
      rst_n = 1'b0;
      addr  = A_COUNT;
      #1;
      check_eq("count_in_reset", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_check("rst_ctrl", A_CTRL, 32'd0);
      rd_check("rst_count", A_COUNT, 32'd0);
      rd_check("rst_compare", A_CMP, 32'hFFFF_FFFF);
      rd_check("rst_status", A_STAT, 32'd0);
      check_eq("rst_sel", {31'd0, sel_v}, 32'd1);
      check_eq("rst_irq", {31'd0, irq_v}, 32'd0);

      // PRESCALE=0: one tick per cycle
      bus_write(A_CTRL, 32'h0000_0001);
      idle(10);
      rd_check("presc0_count", A_COUNT, 32'd10);

      // PRESCALE=3: one tick every 4 cycles
      bus_write(A_CTRL, 32'd0);
      bus_write(A_COUNT, 32'd0);
      bus_write(A_CTRL, 32'h0003_0001);
      idle(40);
      rd_check("presc3_count", A_COUNT, 32'd10);

      // Match with autoreload, COMPARE=5
      bus_write(A_CTRL, 32'd0);
      bus_write(A_COUNT, 32'd0);
      bus_write(A_CMP, 32'd5);
      bus_write(A_CTRL, 32'h0000_0003);
      idle(4);
      rd_check("auto_pre_match", A_STAT, 32'd0);
      rd_check("auto_count_reload", A_COUNT, 32'd0);
      rd_check("auto_match_flag", A_STAT, 32'd1);
      rd_check("auto_count_2", A_COUNT, 32'd2);

      // Match without autoreload keeps counting
      bus_write(A_CTRL, 32'd0);
      bus_write(A_COUNT, 32'd0);
      bus_write(A_STAT, 32'd1);
      bus_write(A_CTRL, 32'h0000_0001);
      idle(6);
      rd_check("noauto_count_6", A_COUNT, 32'd6);
      rd_check("noauto_match", A_STAT, 32'd1);

      // Overflow and OVF write-1-to-clear
      bus_write(A_CTRL, 32'd0);
      bus_write(A_CMP, 32'h0000_1000);
      bus_write(A_STAT, 32'd3);
      bus_write(A_COUNT, 32'hFFFF_FFFE);
      bus_write(A_CTRL, 32'h0000_0001);
      idle(2);
      rd_check("ovf_count_wrap", A_COUNT, 32'd0);
      rd_check("ovf_flag", A_STAT, 32'd2);
      bus_write(A_STAT, 32'd2);
      rd_check("ovf_cleared", A_STAT, 32'd0);

      // W1C of MATCH racing a new match: set wins; a clear in a quiet cycle works
      bus_write(A_CTRL, 32'd0);
      bus_write(A_COUNT, 32'd0);
      bus_write(A_CMP, 32'd2);
      bus_write(A_STAT, 32'd3);
      bus_write(A_CTRL, 32'h0000_0003);
      idle(3);
      bus_write(A_STAT, 32'd1);
      rd_check("race_set_wins", A_STAT, 32'd1);
      idle(1);
      bus_write(A_STAT, 32'd1);
      rd_check("w1c_quiet", A_STAT, 32'd0);

      // COUNT write in a tick cycle wins, flags from that tick still set
      bus_write(A_CTRL, 32'd0);
      bus_write(A_CMP, 32'h0000_1000);
      bus_write(A_COUNT, 32'hFFFF_FFFF);
      bus_write(A_STAT, 32'd3);
      bus_write(A_CTRL, 32'h0000_0001);
      bus_write(A_COUNT, 32'h0000_0100);
      rd_check("count_wr_wins", A_COUNT, 32'h0000_0100);
      rd_check("count_wr_ovf", A_STAT, 32'd2);

      // CTRL unimplemented bits and decode
      bus_write(A_CTRL, 32'hFFFF_FFFE);
`ifdef TIMER_IRQ_EN
      rd_check("ctrl_readback", A_CTRL, 32'hFFFF_0006);
`else
      rd_check("ctrl_readback", A_CTRL, 32'hFFFF_0002);
`endif
      bus_write(A_CTRL, 32'd0);
      bus_write(A_COUNT, 32'h0000_0055);
      bus_read(BASE + 32'h10);
      check_eq("miss_rdata", rd_v, 32'd0);
      check_eq("miss_sel", {31'd0, sel_v}, 32'd0);
      bus_write(BASE + 32'h14, 32'h0000_1234);
      bus_write(BASE + 32'h10, 32'h0000_FFFF);
      rd_check("miss_no_write", BASE + 32'h7, 32'h0000_0055);
      check_eq("hit_sel", {31'd0, sel_v}, 32'd1);
      rd_check("miss_ctrl_kept", A_CTRL, 32'd0);

`ifdef TIMER_IRQ_EN
      // Interrupt follows MATCH by one cycle and drops one cycle after W1C
      bus_write(A_COUNT, 32'd0);
      bus_write(A_STAT, 32'd3);
      bus_write(A_CMP, 32'd2);
      bus_write(A_CTRL, 32'h0000_0005);
      bus_read(A_STAT);
      check_eq("irq_c1_stat", rd_v, 32'd0);
      check_eq("irq_c1", {31'd0, irq_v}, 32'd0);
      bus_read(A_STAT);
      check_eq("irq_c2", {31'd0, irq_v}, 32'd0);
      bus_read(A_STAT);
      check_eq("irq_c3_stat", rd_v, 32'd1);
      check_eq("irq_c3", {31'd0, irq_v}, 32'd0);
      bus_read(A_STAT);
      check_eq("irq_c4", {31'd0, irq_v}, 32'd1);
      bus_write(A_STAT, 32'd1);
      bus_read(A_STAT);
      check_eq("irq_clr_stat", rd_v, 32'd0);
      check_eq("irq_clr_hold", {31'd0, irq_v}, 32'd1);
      bus_read(A_STAT);
      check_eq("irq_clr_drop", {31'd0, irq_v}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/counter that acts as a responder on the processor data bus.
- Serves the CPU's load/store interface: address, write enable, write data in; read data out.
- Read data is combinational so the single-cycle core completes loads in the same cycle.
- Holds a prescaled 32-bit counter, a compare register and sticky status flags; sits beside data RAM behind the top-level bus decode.

Parameters:
- ADDR_DBUS_WIDTH, 32, data bus address width.
- DATA_DBUS_WIDTH, 32, data bus data width; must be 32.
- BASE_ADDR, 32'h0001_0000, base of the 16-byte register window; must be 16-byte aligned.

Ports:
- i_Clock  in  1  system clock; all state changes on the rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_MemAddr  in  ADDR_DBUS_WIDTH  byte address from the CPU.
- i_MemWrEnable  in  1  store strobe, one cycle per store.
- i_MemWrData  in  DATA_DBUS_WIDTH  store data.
- o_MemRdData  out  DATA_DBUS_WIDTH  load data; combinational from address and registers.
- o_Sel  out  1  high when i_MemAddr hits the window; the top level uses it to mux read data.
- o_Irq  out  1  interrupt; present only with TIMER_IRQ_EN.

Behaviour:
- Decode:
  - Hit when i_MemAddr[ADDR_DBUS_WIDTH-1:4] == BASE_ADDR[ADDR_DBUS_WIDTH-1:4].
  - Register select is i_MemAddr[3:2]; bits [1:0] are ignored.
  - On a miss: o_Sel=0, o_MemRdData=0, writes are ignored.
- Register map:
  - 0x0 CTRL: bit0 EN; bit1 AUTORELOAD; bit2 IRQEN; [31:16] PRESCALE. Other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: bit0 MATCH; bit1 OVF. Both write-1-to-clear; other bits read 0.
- Reset (i_Reset low, asynchronous): all registers and the prescale counter go to 0; o_Irq=0. COMPARE resets to 0xFFFFFFFF. A mid-count reset aborts immediately, with no pending tick.
- Prescaler:
  - 16-bit pcnt increments every cycle while EN=1.
  - When pcnt==PRESCALE, pcnt<=0 and a tick is generated that cycle.
  - Tick period is PRESCALE+1 cycles, so PRESCALE=0 gives a tick every cycle.
  - A write to CTRL clears pcnt.
  - While EN=0, pcnt holds 0 and no ticks occur.
- On a tick, with next = COUNT+1 (mod 2^32):
  - If COUNT==0xFFFFFFFF: OVF<=1.
  - If next==COMPARE: MATCH<=1, and COUNT<=0 if AUTORELOAD=1, else COUNT<=next.
  - Otherwise COUNT<=next.
- Simultaneous events:
  - A CPU write to COUNT in a tick cycle wins; the tick increment is discarded, but flag setting from that tick still occurs.
  - A W1C of a flag in the same cycle that hardware sets it: the set wins and the flag stays 1.
  - A COMPARE write takes effect for ticks from the next cycle on.
- Latency:
  - Register writes are visible on reads the cycle after the store edge.
  - Flags are visible the cycle after the tick edge.

Optional Feature:
- TIMER_IRQ_EN defined:
  - o_Irq port exists.
  - o_Irq is registered: o_Irq <= IRQEN & (MATCH | OVF).
  - It is level-type and drops one cycle after software clears the flags or IRQEN.
- TIMER_IRQ_EN undefined:
  - No o_Irq port.
  - CTRL bit2 is not implemented and reads 0.

Test Plan:
- Reset: hold i_Reset=0 mid-count, then release → reads at 0x1_0000/4/8/C return 0, 0, 0xFFFFFFFF, 0; o_Irq=0.
- PRESCALE=0: write CTRL=0x1, idle 10 cycles, read COUNT → 10 (±1 for the write/read cycle, fixed by the bench timing); PRESCALE=3 over 40 cycles → 10.
- Match with autoreload: COMPARE=5, CTRL=0x3 → MATCH sets on the 5th tick, COUNT reads 0 next cycle, then 1, 2…; with AUTORELOAD=0, COUNT continues to 6.
- Overflow: write COUNT=0xFFFFFFFE, EN=1, PRESCALE=0 → two cycles later COUNT=0 and OVF=1; write STATUS=0x2 → OVF=0.
- Races: W1C of MATCH in a cycle where a new match occurs → MATCH stays 1; COUNT write of 0x100 coinciding with a tick → reads 0x100.
- Decode miss and IRQ: access 0x1_0010 → o_Sel=0, rdata 0, no register changes. With TIMER_IRQ_EN, CTRL=0x5 and COMPARE=2 → o_Irq rises one cycle after MATCH sets and falls one cycle after W1C.
